// File: rtl/ex_pkg.sv
// Shared types and sizing for the execute stage and its lane ALUs.
package ex_pkg;

  localparam int unsigned LANE_W          = 32;
  localparam int unsigned LANES           = 6;
  localparam int unsigned LANES_PER_CYCLE = 2;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    VSRC_RVS3 = 2'b00,
    VSRC_RSS3 = 2'b01,
    VSRC_NUM  = 2'b10,
    VSRC_ZERO = 2'b11
  } vsrc_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ex_state_e;

endpackage

// File: rtl/lane_alu.sv
// Combinational single-lane ALU; every op wraps modulo 2^W.
module lane_alu
  import ex_pkg::*;
#(
  parameter int unsigned W = LANE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_MUL: y = a * b;
      ALU_XOR: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/stage_execute.sv
// EX stage: combinational scalar ALU and branch resolution, plus a lane-serial
// vector ALU that stalls upstream until the full vector result is available.
module stage_execute #(
  parameter int unsigned LANES           = ex_pkg::LANES,
  parameter int unsigned LANE_W          = ex_pkg::LANE_W,
  parameter int unsigned LANES_PER_CYCLE = ex_pkg::LANES_PER_CYCLE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      JumpI_in,
  input  logic                      JumpCI_in,
  input  logic                      JumpCD_in,
  input  logic                      MemToReg_in,
  input  logic                      MemWrite_in,
  input  logic [1:0]                ALUOp_in,
  input  logic                      VectorOp_in,
  input  logic                      ALUSrc2_in,
  input  logic [1:0]                ALUSrc3_in,
  input  logic [LANE_W-1:0]         pc_in,
  input  logic [LANE_W-1:0]         RSS1_in,
  input  logic [LANE_W-1:0]         RSS2_in,
  input  logic [LANE_W-1:0]         RSS3_in,
  input  logic [LANES*LANE_W-1:0]   RVS2_in,
  input  logic [LANES*LANE_W-1:0]   RVS3_in,
  input  logic [3:0]                RD_in,
  input  logic [LANE_W-1:0]         num_in,
  input  logic                      RegSWrite_in,
  input  logic                      RegVWrite_in,
  output logic [LANE_W-1:0]         alu_s_out,
  output logic [LANES*LANE_W-1:0]   alu_v_out,
  output logic [LANE_W-1:0]         store_data_out,
  output logic [3:0]                RD_out,
  output logic                      MemToReg_out,
  output logic                      MemWrite_out,
  output logic                      RegSWrite_out,
  output logic                      RegVWrite_out,
  output logic                      branch_taken_out,
  output logic [LANE_W-1:0]         branch_target_out,
  output logic                      stall_out
);

  import ex_pkg::*;

  localparam int unsigned N     = LANES / LANES_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LI_W  = (LANES > 1) ? $clog2(LANES) : 1;

  generate
    if ((LANES % LANES_PER_CYCLE) != 0) begin : g_bad_lanes
      $error("stage_execute: LANES_PER_CYCLE must divide LANES");
    end
  endgenerate

  ex_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [LANE_W-1:0]  acc   [LANES];
  logic [LANE_W-1:0]  va    [LANES];
  logic [LANE_W-1:0]  v3    [LANES];
  logic [LANE_W-1:0]  vmerge[LANES];

  logic [LI_W-1:0]    li    [LANES_PER_CYCLE];
  logic [LANE_W-1:0]  vb    [LANES_PER_CYCLE];
  logic [LANE_W-1:0]  vres  [LANES_PER_CYCLE];

  logic [CNT_W-1:0]   chunk;
  logic [LANE_W-1:0]  s_b;
  logic [LANE_W-1:0]  alu_s;
  logic               last;
  logic               stall;
  logic               taken;
  logic               run;

  // Scalar path
  assign s_b = ALUSrc2_in ? num_in : RSS3_in;

  lane_alu #(.W(LANE_W)) u_scalar (
    .a  (RSS2_in),
    .b  (s_b),
    .op (alu_op_e'(ALUOp_in)),
    .y  (alu_s)
  );

  // Unpack vector operands into lanes
  for (genvar i = 0; i < LANES; i++) begin : g_unpack
    assign va[i] = RVS2_in[i*LANE_W +: LANE_W];
    assign v3[i] = RVS3_in[i*LANE_W +: LANE_W];
  end

  assign chunk = (state == ST_BUSY) ? cnt : '0;

  // Per-cycle vector lanes of the current chunk
  for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_vlane
    assign li[j] = LI_W'(chunk) * LI_W'(LANES_PER_CYCLE) + LI_W'(j);

    always_comb begin
      vb[j] = '0;
      case (vsrc_e'(ALUSrc3_in))
        VSRC_RVS3: vb[j] = v3[li[j]];
        VSRC_RSS3: vb[j] = RSS3_in;
        VSRC_NUM:  vb[j] = num_in;
        VSRC_ZERO: vb[j] = '0;
      endcase
    end

    lane_alu #(.W(LANE_W)) u_vec (
      .a  (va[li[j]]),
      .b  (vb[j]),
      .op (alu_op_e'(ALUOp_in)),
      .y  (vres[j])
    );
  end

  assign last  = VectorOp_in &&
                 ((N == 1) || (state == ST_BUSY && cnt == CNT_W'(N - 1)));
  assign stall = VectorOp_in && !last;

  // Earlier chunks from the accumulator, final chunk straight from the ALUs
  always_comb begin
    for (int i = 0; i < LANES; i++) vmerge[i] = acc[i];
    for (int j = 0; j < LANES_PER_CYCLE; j++) vmerge[li[j]] = vres[j];
  end

  // Chunk sequencer; advances with the pipeline registers on negedge
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (VectorOp_in && (N > 1)) begin
            state <= ST_BUSY;
            cnt   <= CNT_W'(1);
            for (int j = 0; j < LANES_PER_CYCLE; j++) acc[li[j]] <= vres[j];
          end
        end
        ST_BUSY: begin
          for (int j = 0; j < LANES_PER_CYCLE; j++) acc[li[j]] <= vres[j];
          if (cnt == CNT_W'(N - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output gating: everything zero in reset, bubble while stalled
  assign run   = !rst;
  assign taken = JumpI_in | (JumpCI_in & (alu_s == '0)) | (JumpCD_in & (alu_s != '0));

  assign alu_s_out         = run ? alu_s : '0;
  assign store_data_out    = run ? RSS1_in : '0;
  assign RD_out            = run ? RD_in : '0;
  assign branch_target_out = run ? (pc_in + num_in) : '0;
  assign MemToReg_out      = run & MemToReg_in;
  assign MemWrite_out      = run & !stall & MemWrite_in;
  assign RegSWrite_out     = run & !stall & RegSWrite_in;
  assign RegVWrite_out     = run & !stall & RegVWrite_in;
  assign branch_taken_out  = run & !stall & taken;
  assign stall_out         = run & stall;

  for (genvar i = 0; i < LANES; i++) begin : g_pack
    assign alu_v_out[i*LANE_W +: LANE_W] = (run && last) ? vmerge[i] : '0;
  end

endmodule

// File: tb/tb_stage_execute.sv
// Directed bench for stage_execute: scalar vector table plus multi-cycle vector sequences.
module tb_stage_execute;

  logic         clk = 1'b0;
  logic         rst;
  logic         JumpI_in, JumpCI_in, JumpCD_in, MemToReg_in, MemWrite_in;
  logic [1:0]   ALUOp_in;
  logic         VectorOp_in, ALUSrc2_in;
  logic [1:0]   ALUSrc3_in;
  logic [31:0]  pc_in, RSS1_in, RSS2_in, RSS3_in, num_in;
  logic [191:0] RVS2_in, RVS3_in;
  logic [3:0]   RD_in;
  logic         RegSWrite_in, RegVWrite_in;
  logic [31:0]  alu_s_out, store_data_out, branch_target_out;
  logic [191:0] alu_v_out;
  logic [3:0]   RD_out;
  logic         MemToReg_out, MemWrite_out, RegSWrite_out, RegVWrite_out;
  logic         branch_taken_out, stall_out;

  int checks = 0;
  int errors = 0;

  stage_execute dut (
    .clk(clk), .rst(rst),
    .JumpI_in(JumpI_in), .JumpCI_in(JumpCI_in), .JumpCD_in(JumpCD_in),
    .MemToReg_in(MemToReg_in), .MemWrite_in(MemWrite_in),
    .ALUOp_in(ALUOp_in), .VectorOp_in(VectorOp_in),
    .ALUSrc2_in(ALUSrc2_in), .ALUSrc3_in(ALUSrc3_in),
    .pc_in(pc_in), .RSS1_in(RSS1_in), .RSS2_in(RSS2_in), .RSS3_in(RSS3_in),
    .RVS2_in(RVS2_in), .RVS3_in(RVS3_in), .RD_in(RD_in), .num_in(num_in),
    .RegSWrite_in(RegSWrite_in), .RegVWrite_in(RegVWrite_in),
    .alu_s_out(alu_s_out), .alu_v_out(alu_v_out),
    .store_data_out(store_data_out), .RD_out(RD_out),
    .MemToReg_out(MemToReg_out), .MemWrite_out(MemWrite_out),
    .RegSWrite_out(RegSWrite_out), .RegVWrite_out(RegVWrite_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        src2;
    logic        ji, jci, jcd;
    logic [31:0] pc, rss1, rss2, rss3, num;
    logic [3:0]  rd;
    logic        sw;
    logic [31:0] e_alu;
    logic        e_taken;
    logic [31:0] e_tgt;
  } svec_t;

  svec_t tbl [7];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] pk(input logic [31:0] l0, l1, l2, l3, l4, l5);
    return {l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic clear_inputs();
    JumpI_in = 0; JumpCI_in = 0; JumpCD_in = 0; MemToReg_in = 0; MemWrite_in = 0;
    ALUOp_in = 2'b00; VectorOp_in = 0; ALUSrc2_in = 0; ALUSrc3_in = 2'b00;
    pc_in = '0; RSS1_in = '0; RSS2_in = '0; RSS3_in = '0; num_in = '0;
    RVS2_in = '0; RVS3_in = '0; RD_in = '0; RegSWrite_in = 0; RegVWrite_in = 0;
  endtask

  // Runs one 3-cycle vector op; called and returns 1ns after a negedge
  task automatic run_vec(input string nm, input logic [1:0] op, input logic [1:0] src3,
                         input logic [191:0] a, input logic [191:0] b,
                         input logic [31:0] rss3, input logic [31:0] num,
                         input logic [191:0] exp);
    VectorOp_in = 1; ALUOp_in = op; ALUSrc3_in = src3;
    RVS2_in = a; RVS3_in = b; RSS3_in = rss3; num_in = num;
    RegVWrite_in = 1; RegSWrite_in = 0; MemWrite_in = 0;
    JumpI_in = 0; JumpCI_in = 0; JumpCD_in = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("%s stall c%0d", nm, c), 192'(stall_out), 192'(c < 2));
      chk($sformatf("%s vwr c%0d", nm, c), 192'(RegVWrite_out), 192'(c == 2));
      chk($sformatf("%s vout c%0d", nm, c), alu_v_out, (c == 2) ? exp : 192'(0));
      @(negedge clk); #1;
    end
  endtask

  initial begin
    tbl[0] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1111_1111, 32'hFFFF_FFFF, 32'h0,
               32'h2,         4'h3, 1'b1, 32'h0000_0001, 1'b0, 32'h0000_0002};
    tbl[1] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,  32'h2222_2222, 32'h7,         32'h7,
               32'h10,        4'h1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0050};
    tbl[2] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,  32'h3333_3333, 32'h7,         32'h8,
               32'h10,        4'h1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0050};
    tbl[3] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,  32'h4444_4444, 32'h7,         32'h8,
               32'h10,        4'h4, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0050};
    tbl[4] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h5555_5555, 32'h0001_0000, 32'h0001_0001,
               32'hFFFF_FFF0, 4'h7, 1'b1, 32'h0001_0000, 1'b0, 32'h0000_00F0};
    tbl[5] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8,   32'h6666_6666, 32'hA5A5_A5A5, 32'hFFFF_0000,
               32'h4,         4'hF, 1'b1, 32'h5A5A_A5A5, 1'b1, 32'h0000_000C};
    tbl[6] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h7777_7777, 32'h0,         32'h0,
               32'h1,         4'h2, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};

    // Reset: outputs forced to zero even with live inputs
    clear_inputs();
    rst = 1;
    JumpI_in = 1; RegSWrite_in = 1; MemWrite_in = 1; RSS2_in = 32'h5; RSS1_in = 32'h9; RD_in = 4'h6;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    chk("rst alu_s", 192'(alu_s_out), 192'(0));
    chk("rst taken", 192'(branch_taken_out), 192'(0));
    chk("rst stall", 192'(stall_out), 192'(0));
    chk("rst swr", 192'(RegSWrite_out), 192'(0));
    chk("rst mwr", 192'(MemWrite_out), 192'(0));
    chk("rst store", 192'(store_data_out), 192'(0));
    chk("rst vout", alu_v_out, 192'(0));
    @(negedge clk); #1;
    rst = 0;
    clear_inputs();

    // Scalar table
    for (int k = 0; k < 7; k++) begin
      ALUOp_in = tbl[k].op; ALUSrc2_in = tbl[k].src2;
      JumpI_in = tbl[k].ji; JumpCI_in = tbl[k].jci; JumpCD_in = tbl[k].jcd;
      pc_in = tbl[k].pc; RSS1_in = tbl[k].rss1; RSS2_in = tbl[k].rss2;
      RSS3_in = tbl[k].rss3; num_in = tbl[k].num; RD_in = tbl[k].rd;
      RegSWrite_in = tbl[k].sw; MemWrite_in = tbl[k].sw; VectorOp_in = 0;
      @(posedge clk); #1;
      chk($sformatf("s%0d alu_s", k), 192'(alu_s_out), 192'(tbl[k].e_alu));
      chk($sformatf("s%0d taken", k), 192'(branch_taken_out), 192'(tbl[k].e_taken));
      chk($sformatf("s%0d target", k), 192'(branch_target_out), 192'(tbl[k].e_tgt));
      chk($sformatf("s%0d stall", k), 192'(stall_out), 192'(0));
      chk($sformatf("s%0d swr", k), 192'(RegSWrite_out), 192'(tbl[k].sw));
      chk($sformatf("s%0d mwr", k), 192'(MemWrite_out), 192'(tbl[k].sw));
      chk($sformatf("s%0d store", k), 192'(store_data_out), 192'(tbl[k].rss1));
      chk($sformatf("s%0d rd", k), 192'(RD_out), 192'(tbl[k].rd));
      @(negedge clk); #1;
    end
    clear_inputs();

    // Vector MUL with RSS3 broadcast
    run_vec("vmul", 2'b10, 2'b01, pk(1, 2, 3, 4, 5, 6), pk(7, 7, 7, 7, 7, 7), 32'h3, 32'h0,
            pk(3, 6, 9, 12, 15, 18));

    // Back-to-back vector ops, no idle gap
    run_vec("vadd1", 2'b00, 2'b00, pk(32'hFFFF_FFFF, 1, 2, 3, 4, 5), pk(1, 1, 1, 1, 1, 1),
            32'h0, 32'h0, pk(0, 2, 3, 4, 5, 6));
    run_vec("vadd2", 2'b00, 2'b10, pk(32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60),
            pk(9, 9, 9, 9, 9, 9), 32'h5, 32'h100,
            pk(32'h110, 32'h120, 32'h130, 32'h140, 32'h150, 32'h160));
    run_vec("vsubz", 2'b01, 2'b11, pk(32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF),
            pk(9, 9, 9, 9, 9, 9), 32'h5, 32'h6,
            pk(32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF));
    clear_inputs();
    @(posedge clk); #1;
    chk("idle stall", 192'(stall_out), 192'(0));
    chk("idle vout", alu_v_out, 192'(0));
    @(negedge clk); #1;

    // Reset in the second cycle of a vector op
    VectorOp_in = 1; ALUOp_in = 2'b10; ALUSrc3_in = 2'b01; RVS2_in = pk(1, 2, 3, 4, 5, 6);
    RSS3_in = 32'h3; RegVWrite_in = 1;
    @(posedge clk); #1;
    chk("abort c0 stall", 192'(stall_out), 192'(1));
    @(negedge clk); #1;
    chk("abort c1 stall", 192'(stall_out), 192'(1));
    #2 rst = 1;
    #1;
    chk("abort stall", 192'(stall_out), 192'(0));
    chk("abort vwr", 192'(RegVWrite_out), 192'(0));
    chk("abort vout", alu_v_out, 192'(0));
    @(negedge clk); #1;
    chk("abort held vwr", 192'(RegVWrite_out), 192'(0));
    rst = 0;
    run_vec("vmul2", 2'b10, 2'b01, pk(1, 2, 3, 4, 5, 6), pk(7, 7, 7, 7, 7, 7), 32'h3, 32'h0,
            pk(3, 6, 9, 12, 15, 18));
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
